// File: rtl/cpu_pkg.sv
// cpu_pkg -- shared execute-stage types and constants | rev 1.0
`default_nettype none

package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  localparam int MUL_WIDTH = 32;
  // Cycles from the start-sampling edge to the done pulse; used by stall logic.
  localparam int MUL_LAT   = MUL_WIDTH;

endpackage

`default_nettype wire

// File: rtl/mul_seq.sv
// mul_seq -- iterative shift-add multiplier, signed/unsigned, one bit per cycle | rev 1.0
`default_nettype none

module mul_seq
  import cpu_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic               sign,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // Two's-complement negate when neg is set; narrower callers zero-extend and truncate.
  function automatic logic [PW-1:0] cond_neg(input logic [PW-1:0] v, input logic neg);
    return neg ? (~v + PW'(1)) : v;
  endfunction

  mul_state_e     state_q, state_d;
  logic [WIDTH-1:0] ma_q, ma_d;
  logic [WIDTH-1:0] mb_q, mb_d;
  logic [PW:0]      acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic [PW-1:0]    product_q, product_d;

  logic             w_load;
  logic             w_last;
  logic [WIDTH:0]   w_sum;
  logic [PW:0]      w_acc_add;
  logic [PW:0]      w_acc_shr;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  assign w_load    = start && (state_q != RUN);
  assign w_last    = (cnt_q == CNT_LAST);
  assign w_sum     = acc_q[PW:WIDTH] + {1'b0, ma_q};
  assign w_acc_add = mb_q[0] ? {w_sum, acc_q[WIDTH-1:0]} : acc_q;
  assign w_acc_shr = w_acc_add >> 1;
  assign w_mag_a   = WIDTH'(cond_neg({{WIDTH{1'b0}}, op_a}, sign & op_a[WIDTH-1]));
  assign w_mag_b   = WIDTH'(cond_neg({{WIDTH{1'b0}}, op_b}, sign & op_b[WIDTH-1]));

  always_comb begin
    state_d   = state_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;

    if (w_load) begin
      state_d = RUN;
      ma_d    = w_mag_a;
      mb_d    = w_mag_b;
      acc_d   = '0;
      cnt_d   = '0;
      neg_d   = (op_a[WIDTH-1] ^ op_b[WIDTH-1]) & sign;
    end else begin
      unique case (state_q)
        RUN: begin
          acc_d = w_acc_shr;
          mb_d  = mb_q >> 1;
          cnt_d = cnt_q + CW'(1);
          if (w_last) begin
            state_d   = DONE;
            product_d = cond_neg(w_acc_shr[PW-1:0], neg_q);
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      ma_q      <= '0;
      mb_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq.sv
// tb_mul_seq -- randomized self-checking bench for mul_seq against an arithmetic model | rev 1.0
`default_nettype none

module tb_mul_seq;

  localparam int W = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          start = 1'b0;
  logic          sign = 1'b0;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic          busy;
  logic          done;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt  = 0;

  mul_seq #(.WIDTH(W)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .start  (start),
    .sign   (sign),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // True mathematical product, reduced to 64 bits.
  function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic s);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = 64'(a);
    ub = 64'(b);
    return ua * ub;
  endfunction

  // mode 0: inputs untouched; 1: scramble operands every cycle; 2: stray start at cycle 10.
  task automatic wait_done(input int mode, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 100; i++) begin
      if (mode == 1) begin
        op_a = $urandom;
        op_b = $urandom;
        sign = 1'($urandom);
      end
      if (mode == 2) begin
        start = (i == 10);
        if (i == 10) begin
          op_a = $urandom;
          op_b = $urandom;
          sign = ~sign;
        end
      end
      @(posedge CLK);
      #1;
      if (done) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        input int mode, input string tag);
    logic [63:0] exp;
    int          cyc;
    exp   = ref_mul(a, b, s);
    op_a  = a;
    op_b  = b;
    sign  = s;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(mode, cyc);
    check({tag, "_lat"}, 64'(cyc), 64'(W));
    check({tag, "_prod"}, product, exp);
    @(posedge CLK);
    #1;
    check({tag, "_pulse"}, {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    logic [W-1:0] ba[4];
    logic [W-1:0] bb[4];
    logic         bs[4];
    logic [63:0]  exp;
    int           cyc;
    int           t_prev;

    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_prod", product, 64'd0);
    #9 RST = 1'b1;
    @(posedge CLK);
    #1;

    run_op(32'd2000, 32'd2000, 1'b0, 0, "u2000");
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 0, "s_m3x5");
    run_op(32'hFFFF_FFFD, 32'd5, 1'b0, 0, "u_m3x5");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, "s_min");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "u_max");
    run_op(32'd0, 32'hFFFF_FFFF, 1'b1, 0, "zero");
    for (int k = 0; k < 8; k++)
      run_op($urandom, $urandom, 1'($urandom), 0, "rand");
    for (int k = 0; k < 2; k++)
      run_op($urandom, $urandom, 1'($urandom), 1, "hold");
    for (int k = 0; k < 2; k++)
      run_op($urandom, $urandom, 1'($urandom), 2, "poke");

    // Continuous start: each load happens on the cycle after the previous done.
    for (int k = 0; k < 4; k++) begin
      ba[k] = $urandom;
      bb[k] = $urandom;
      bs[k] = 1'($urandom);
    end
    ba[1] = 32'h8000_0000;
    bs[1] = 1'b1;
    op_a  = ba[0];
    op_b  = bb[0];
    sign  = bs[0];
    start = 1'b1;
    @(posedge CLK);
    #1;
    t_prev = 0;
    for (int k = 0; k < 4; k++) begin
      exp = ref_mul(ba[k], bb[k], bs[k]);
      if (k < 3) begin
        op_a = ba[k+1];
        op_b = bb[k+1];
        sign = bs[k+1];
      end else begin
        start = 1'b0;
      end
      wait_done(0, cyc);
      check("b2b_lat", 64'(cyc), 64'(W));
      check("b2b_prod", product, exp);
      if (k > 0) check("b2b_gap", 64'(cyc_cnt - t_prev), 64'(W + 1));
      t_prev = cyc_cnt;
      @(posedge CLK);
      #1;
      check("b2b_pulse", 64'(done), 64'd0);
      check("b2b_busy", 64'(busy), (k < 3) ? 64'd1 : 64'd0);
    end

    // Abort mid-RUN with asynchronous reset between clock edges.
    run_op($urandom | 32'h1, $urandom | 32'h1, 1'b0, 0, "pre_rst");
    op_a  = $urandom;
    op_b  = $urandom;
    start = 1'b1;
    @(posedge CLK);
    #1;
    start = 1'b0;
    repeat (15) @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_prod", product, 64'd0);
    #2 RST = 1'b1;
    @(posedge CLK);
    #1;
    check("arst_idle", {62'd0, done, busy}, 64'd0);
    run_op($urandom, $urandom, 1'b1, 0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/mul_seq.md
# mul_seq

Iterative shift-add multiplier for the CPU execute stage. It computes the 2·WIDTH-bit product of two WIDTH-bit operands, signed or unsigned, one partial product per CLK cycle. WIDTH = 32 matches the 32-CLK system period. The result feeds the `writeBack` path directly downstream, and the `done` pulse tells the pipeline when the result is valid.

## Interface
- `WIDTH`, default 32: operand width in bits; product is 2·WIDTH bits.
- `CLK`  in  1: single clock; all state changes on the rising edge.
- `RST`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled only in IDLE or DONE.
- `sign`  in  1: 1 = two's-complement operands, 0 = unsigned; latched with `start`.
- `op_a`  in  WIDTH: multiplicand; latched with `start`.
- `op_b`  in  WIDTH: multiplier; latched with `start`.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse; `product` is valid from this cycle on.
- `product`  out  2·WIDTH: result register; holds until the next completion.

## Operation
- States:
  - IDLE: reset state.
  - RUN: WIDTH iterations.
  - DONE: lasts one cycle.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→DONE when the iteration counter reaches WIDTH−1.
  - DONE→RUN on `start`, otherwise DONE→IDLE.
- Load (the edge that samples `start`):
  - Store |op_a| and |op_b|. When `sign`=0, each magnitude is the raw value. When `sign`=1, a negative operand is negated modulo 2^WIDTH, so 0x80000000 gives the magnitude 0x80000000.
  - Store the result sign as a[WIDTH−1]^b[WIDTH−1]&sign.
  - Clear the accumulator (2·WIDTH+1 bits) and the counter.
- Each RUN cycle:
  - If the multiplier LSB is 1, add the multiplicand into the upper half of the accumulator.
  - Shift accumulator and multiplier right by 1.
  - Increment the counter (log2(WIDTH) bits, wraps at WIDTH).
- On the final RUN edge:
  - Write `product` with the accumulated value, two's-complement negated over 2·WIDTH bits if the result sign is set.
  - `done`=1 for exactly the following cycle.
- `start` while in RUN is ignored and is not queued. Changes to `op_a`, `op_b` and `sign` during RUN have no effect.
- `start` in the DONE cycle begins a new operation back-to-back: `busy` rises the next cycle and `product` keeps the previous result until the new completion.
- Zero operands are not special-cased and take the full WIDTH cycles.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `product`=0, counter 0, accumulator 0.
- Reset asserted mid-RUN aborts immediately. No `done` is produced and `product` returns to 0.
- Latency: `start` sampled at edge E0. `busy`=1 from E0 to E(WIDTH). `done`=1 and the new `product` are visible after edge E(WIDTH), i.e. WIDTH cycles after the sampling edge.
- Throughput: one operation per WIDTH+1 cycles with continuous `start`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- The shared `cpu_pkg` package holds:
  - the state enum (IDLE, RUN, DONE),
  - the `WIDTH` default (32),
  - `MUL_LAT` = WIDTH, used by the pipeline stall logic.
- No sub-modules. The conditional two's-complement negate is a local function, used for both operand magnitudes and the result.

## Test plan
- Unsigned: `sign`=0, `op_a`=2000, `op_b`=2000 → `done` 32 cycles after the sampling edge; `product`=0x0000_0000_003D_0900 (4 000 000). This is the CPU's (4001−2001)·(5001−3001) case.
- Signed: `sign`=1, `op_a`=0xFFFF_FFFD (−3), `op_b`=5 → `product`=0xFFFF_FFFF_FFFF_FFF1 (−15). With `sign`=0 and the same operands → `product`=0x0000_0004_FFFF_FFF1.
- Extremes, signed then unsigned:
  - 0x8000_0000 × 0x8000_0000 with `sign`=1 → 0x4000_0000_0000_0000.
  - 0xFFFF_FFFF × 0xFFFF_FFFF with `sign`=0 → 0xFFFF_FFFE_0000_0001.
- Back-to-back:
  - Hold `start` high continuously → `done` pulses every 33 cycles, one cycle wide, each with the correct result.
  - Pulse `start` mid-RUN with different operands → ignored, and the first result is unaffected.
- Reset mid-op: drop `RST` at cycle 15 of RUN → `busy`, `done` and `product` go to 0 immediately without waiting for an edge. A later `start` completes normally.
- Operand hold: change `op_a`/`op_b` every cycle during RUN → `product` equals the product of the values sampled at the `start` edge.
